fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Parametrised instruction buffer between the WIDTH-lane fetch stage and decode of the multi-issue pipeline.
- Generalises the fixed two-lane imem a/b fetch path to WIDTH lanes.
- Decouples fetch from decode stalls: accepts up to WIDTH instructions per cycle, presents up to WIDTH oldest instructions in program order, and is emptied on a branch/jump redirect.

Parameters:
WIDTH, 2, number of fetch/issue lanes (1..4)
DEPTH, 8, queue entries; power of two, DEPTH >= 2*WIDTH
DATA_W, 32, instruction width
ADDR_W, 12, PC width (matches imem address width)

Ports:
clock  input  1  master clock; all state updates on rising edge
reset  input  1  synchronous, active-low (0 = reset), sampled on rising edge of clock
in_valid  input  WIDTH  per-lane fetch valid; lane 0 is oldest; must be contiguous from lane 0
in_instr  input  WIDTH*DATA_W  lane i at bits [i*DATA_W +: DATA_W]
in_pc  input  WIDTH*ADDR_W  lane i PC at bits [i*ADDR_W +: ADDR_W]
in_ready  output  1  high when free entries >= WIDTH
out_valid  output  WIDTH  out_valid[i] = (count > i)
out_instr  output  WIDTH*DATA_W  entry head+i in lane i
out_pc  output  WIDTH*ADDR_W  PC of entry head+i
out_take  input  $clog2(WIDTH+1)  number of entries decode consumes this cycle
flush  input  1  redirect; discard all contents
count  output  $clog2(DEPTH+1)  current occupancy
err  output  1  sticky protocol-violation flag

Behaviour:
- State: DEPTH x (DATA_W+ADDR_W) storage, head and tail pointers (log2 DEPTH bits, wrap modulo DEPTH), and count.
- Reset (reset==0 at an edge): head=tail=count=0 and err=0. Resulting outputs: out_valid=0, in_ready=1. Storage contents are don't-care.
- in_ready is combinational from the registered count only: in_ready = (DEPTH - count >= WIDTH). It does not consider a same-cycle pop.
- Push:
  - n_push = popcount(in_valid) when in_ready==1 and in_valid is contiguous; otherwise n_push = 0.
  - Lane i is written to entry (tail+i) mod DEPTH.
  - tail advances by n_push.
- Non-contiguous in_valid (e.g. 2'b10): push dropped entirely; err set.
- Asserting in_valid != 0 while in_ready==0: push dropped; err set.
- Pop:
  - n_pop = out_take when out_take <= count and out_take <= WIDTH.
  - Otherwise n_pop = 0 and err is set.
  - head advances by n_pop.
- Simultaneous push and pop: count_next = count + n_push - n_pop. Storage writes never collide with valid unread entries, guaranteed by the in_ready rule.
- Output path:
  - out_* are combinational reads of entries (head+i) mod DEPTH.
  - Lanes with i >= count show don't-care data with out_valid[i]=0.
- Latency: an instruction pushed at edge N is visible on out_* after edge N (zero bubble). No same-cycle bypass from in_* to out_*.
- Flush:
  - At the edge: head=tail=count=0.
  - Overrides any push and pop in that cycle; no err is generated for an out_take or push in that cycle.
- Order of precedence: reset > flush > push/pop.
- err is sticky until reset.
- Wrap-around: pointers wrap silently. A multi-lane push or pop straddling entry DEPTH-1 to entry 0 must keep program order.
- Full: count==DEPTH is legal. Empty: count==0, out_valid=0.

Test Plan:
- Reset then idle, WIDTH=2, DEPTH=8 -> count=0, out_valid=2'b00, in_ready=1, err=0.
- Push in_valid=2'b11 with instr 0xA0/0xA1, pc 0x010/0x011, out_take=0 -> next cycle count=2, out_valid=2'b11, lane0 instr=0xA0 pc=0x010, lane1 instr=0xA1.
- Push 2'b11 for 4 cycles (8 entries), out_take=0 -> count=8, in_ready=0. A further push is ignored, err=1, and count stays 8.
- Fill to 6; take 2 and push 2 each cycle for 5 cycles so pointers wrap -> count stays 6, and out_instr sequence on lane 0 strictly follows push order across the entry 7->0 boundary.
- count=5, flush=1 with push 2'b11 and out_take=2 the same cycle -> next cycle count=0, out_valid=0, err unchanged.
- count=1, out_take=2 -> err=1, count stays 1. Separately, in_valid=2'b10 -> err=1, nothing written.
- reset=0 asserted mid-stream with count=4 and err=1 -> next cycle count=0, err=0, in_ready=1.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch-side push and decode-side pop bundle for the fetch queue.
// The master drives fetch and decode requests; the slave is the queue.
interface fetch_queue_if #(
  parameter int WIDTH  = 2,
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
);
  localparam int TAKE_W = $clog2(WIDTH + 1);
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]        in_valid;
  logic [WIDTH*DATA_W-1:0] in_instr;
  logic [WIDTH*ADDR_W-1:0] in_pc;
  logic                    in_ready;
  logic [WIDTH-1:0]        out_valid;
  logic [WIDTH*DATA_W-1:0] out_instr;
  logic [WIDTH*ADDR_W-1:0] out_pc;
  logic [TAKE_W-1:0]       out_take;
  logic                    flush;
  logic [CNT_W-1:0]        count;
  logic                    err;

  modport master (
    output in_valid, in_instr, in_pc, out_take, flush,
    input  in_ready, out_valid, out_instr, out_pc, count, err
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_take, flush,
    output in_ready, out_valid, out_instr, out_pc, count, err
  );
endinterface

// File: rtl/fetch_queue.sv
// Multi-lane instruction buffer between fetch and decode: up to WIDTH pushes
// and WIDTH pops per cycle in program order, emptied on redirect.
module fetch_queue #(
  parameter int WIDTH  = 2,
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
) (
  input  logic          clock,
  input  logic          reset,
  fetch_queue_if.slave  bus
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int TAKE_W = $clog2(WIDTH + 1);

  logic [DATA_W-1:0] instr_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem    [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count_q;
  logic             err_q;

  logic             ready;
  logic             contig;
  logic             push_ok;
  logic             push_err;
  logic             pop_ok;
  logic             pop_err;
  logic [CNT_W-1:0] n_push;
  logic [CNT_W-1:0] n_pop;

  function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction

  // Valid lanes must be a run of ones starting at lane 0, i.e. v+1 is a power of two.
  function automatic logic is_contiguous(input logic [WIDTH-1:0] v);
    return ((v & (v + WIDTH'(1))) == '0);
  endfunction

  always_comb begin
    ready    = (count_q <= CNT_W'(DEPTH - WIDTH));
    contig   = is_contiguous(bus.in_valid);
    push_ok  = ready && contig && (bus.in_valid != '0);
    push_err = (bus.in_valid != '0) && !(ready && contig);
    pop_ok   = (CNT_W'(bus.out_take) <= count_q) && (bus.out_take <= TAKE_W'(WIDTH));
    pop_err  = !pop_ok;
    n_push   = push_ok ? popcount(bus.in_valid) : '0;
    n_pop    = pop_ok ? CNT_W'(bus.out_take) : '0;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else if (bus.flush) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      head    <= head + PTR_W'(n_pop);
      tail    <= tail + PTR_W'(n_push);
      count_q <= count_q + n_push - n_pop;
      if (push_err || pop_err) err_q <= 1'b1;
    end
  end

  // Storage is data only; the in_ready rule keeps writes off unread entries.
  always_ff @(posedge clock) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (reset && !bus.flush && push_ok && bus.in_valid[i]) begin
        instr_mem[tail + PTR_W'(i)] <= bus.in_instr[i*DATA_W +: DATA_W];
        pc_mem[tail + PTR_W'(i)]    <= bus.in_pc[i*ADDR_W +: ADDR_W];
      end
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    assign bus.out_valid[g]                   = (count_q > CNT_W'(g));
    assign bus.out_instr[g*DATA_W +: DATA_W]  = instr_mem[head + PTR_W'(g)];
    assign bus.out_pc[g*ADDR_W +: ADDR_W]     = pc_mem[head + PTR_W'(g)];
  end

  assign bus.in_ready = ready;
  assign bus.count    = count_q;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fetch_queue;
  localparam int WIDTH  = 2;
  localparam int DEPTH  = 8;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 12;

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
  } ent_t;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  bit   chk_en;

  ent_t q[$];
  bit   merr;

  fetch_queue_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  fetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain FIFO of entries plus a sticky error bit.
  always @(posedge clock) begin
    bit contig;
    bit seen_zero;
    bit ready;
    int take;
    if (!reset) begin
      q.delete();
      merr = 1'b0;
    end else if (bus.flush) begin
      q.delete();
    end else begin
      contig    = 1'b1;
      seen_zero = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        if (!bus.in_valid[i]) seen_zero = 1'b1;
        else if (seen_zero) contig = 1'b0;
      end
      ready = (DEPTH - q.size() >= WIDTH);
      take  = int'(bus.out_take);
      if (take <= q.size() && take <= WIDTH) begin
        for (int i = 0; i < take; i++) void'(q.pop_front());
      end else begin
        merr = 1'b1;
      end
      if (bus.in_valid != '0) begin
        if (contig && ready) begin
          for (int i = 0; i < WIDTH; i++)
            if (bus.in_valid[i])
              q.push_back({bus.in_instr[i*DATA_W +: DATA_W], bus.in_pc[i*ADDR_W +: ADDR_W]});
        end else begin
          merr = 1'b1;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      cmp("count", 64'(bus.count), 64'(q.size()));
      cmp("in_ready", 64'(bus.in_ready), 64'(DEPTH - q.size() >= WIDTH));
      cmp("err", 64'(bus.err), 64'(merr));
      for (int i = 0; i < WIDTH; i++) begin
        cmp("out_valid", 64'(bus.out_valid[i]), 64'(q.size() > i));
        if (q.size() > i) begin
          cmp("out_instr", 64'(bus.out_instr[i*DATA_W +: DATA_W]), 64'(q[i].instr));
          cmp("out_pc", 64'(bus.out_pc[i*ADDR_W +: ADDR_W]), 64'(q[i].pc));
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                       input logic [11:0] p0, input logic [11:0] p1,
                       input logic [1:0] take, input logic fl);
    bus.in_valid = v;
    bus.in_instr = {i1, i0};
    bus.in_pc    = {p1, p0};
    bus.out_take = take;
    bus.flush    = fl;
  endtask

  task automatic idle();
    drive(2'b00, 32'h0, 32'h0, 12'h0, 12'h0, 2'd0, 1'b0);
  endtask

  initial begin
    int r;
    int mx;
    logic [1:0] v;
    logic [1:0] tk;
    checks = 0;
    errors = 0;
    chk_en = 1'b0;
    merr   = 1'b0;
    reset  = 1'b0;
    idle();
    cycle();
    cycle();
    chk_en = 1'b1;
    reset  = 1'b1;
    cycle();

    // Reset then idle
    cmp("rst_count", 64'(bus.count), 64'd0);
    cmp("rst_out_valid", 64'(bus.out_valid), 64'd0);
    cmp("rst_in_ready", 64'(bus.in_ready), 64'd1);
    cmp("rst_err", 64'(bus.err), 64'd0);

    // First two-lane push
    drive(2'b11, 32'hA0, 32'hA1, 12'h010, 12'h011, 2'd0, 1'b0);
    cycle();
    cmp("push_count", 64'(bus.count), 64'd2);
    cmp("push_out_valid", 64'(bus.out_valid), 64'd3);
    cmp("push_lane0_instr", 64'(bus.out_instr[31:0]), 64'hA0);
    cmp("push_lane0_pc", 64'(bus.out_pc[11:0]), 64'h010);
    cmp("push_lane1_instr", 64'(bus.out_instr[63:32]), 64'hA1);
    cmp("push_lane1_pc", 64'(bus.out_pc[23:12]), 64'h011);

    // Fill to full, then overflow
    for (int k = 0; k < 3; k++) begin
      drive(2'b11, 32'hA2 + 2*k, 32'hA3 + 2*k, 12'h012 + 12'(2*k), 12'h013 + 12'(2*k), 2'd0, 1'b0);
      cycle();
    end
    cmp("full_count", 64'(bus.count), 64'd8);
    cmp("full_in_ready", 64'(bus.in_ready), 64'd0);
    cmp("full_err_before", 64'(bus.err), 64'd0);
    drive(2'b11, 32'hFF, 32'hFE, 12'hFFF, 12'hFFE, 2'd0, 1'b0);
    cycle();
    cmp("overflow_err", 64'(bus.err), 64'd1);
    cmp("overflow_count", 64'(bus.count), 64'd8);
    cmp("overflow_head", 64'(bus.out_instr[31:0]), 64'hA0);

    // Drain to 4, then reset mid-stream
    drive(2'b00, 32'h0, 32'h0, 12'h0, 12'h0, 2'd2, 1'b0);
    cycle();
    cycle();
    cmp("drain_count", 64'(bus.count), 64'd4);
    cmp("drain_head", 64'(bus.out_instr[31:0]), 64'hA4);
    idle();
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    cmp("midrst_count", 64'(bus.count), 64'd0);
    cmp("midrst_err", 64'(bus.err), 64'd0);
    cmp("midrst_in_ready", 64'(bus.in_ready), 64'd1);

    // Offset pointers by one so pushes and pops straddle entry 7 -> 0
    drive(2'b01, 32'hEE, 32'h0, 12'h0EE, 12'h0, 2'd0, 1'b0);
    cycle();
    drive(2'b00, 32'h0, 32'h0, 12'h0, 12'h0, 2'd1, 1'b0);
    cycle();
    cmp("offset_count", 64'(bus.count), 64'd0);
    for (int k = 0; k < 3; k++) begin
      drive(2'b11, 32'hB0 + 2*k, 32'hB1 + 2*k, 12'h100 + 12'(2*k), 12'h101 + 12'(2*k), 2'd0, 1'b0);
      cycle();
    end
    cmp("wrap_fill_count", 64'(bus.count), 64'd6);
    for (int k = 0; k < 5; k++) begin
      cmp("wrap_lane0", 64'(bus.out_instr[31:0]), 64'(32'hB0 + 2*k));
      cmp("wrap_lane1", 64'(bus.out_instr[63:32]), 64'(32'hB1 + 2*k));
      drive(2'b11, 32'hB6 + 2*k, 32'hB7 + 2*k, 12'h106 + 12'(2*k), 12'h107 + 12'(2*k), 2'd2, 1'b0);
      cycle();
      cmp("wrap_count", 64'(bus.count), 64'd6);
    end
    cmp("wrap_lane0_end", 64'(bus.out_instr[31:0]), 64'hBA);
    cmp("wrap_pc0_end", 64'(bus.out_pc[11:0]), 64'h10A);

    // Flush overrides same-cycle push and pop
    drive(2'b00, 32'h0, 32'h0, 12'h0, 12'h0, 2'd1, 1'b0);
    cycle();
    cmp("preflush_count", 64'(bus.count), 64'd5);
    drive(2'b11, 32'hC0, 32'hC1, 12'h200, 12'h201, 2'd2, 1'b1);
    cycle();
    idle();
    cmp("flush_count", 64'(bus.count), 64'd0);
    cmp("flush_out_valid", 64'(bus.out_valid), 64'd0);
    cmp("flush_err", 64'(bus.err), 64'd0);

    // Over-take with one entry
    drive(2'b01, 32'hD0, 32'h0, 12'h300, 12'h0, 2'd0, 1'b0);
    cycle();
    cmp("one_count", 64'(bus.count), 64'd1);
    drive(2'b00, 32'h0, 32'h0, 12'h0, 12'h0, 2'd2, 1'b0);
    cycle();
    idle();
    cmp("overtake_err", 64'(bus.err), 64'd1);
    cmp("overtake_count", 64'(bus.count), 64'd1);

    // Non-contiguous push after a reset
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    drive(2'b10, 32'hD1, 32'hD2, 12'h301, 12'h302, 2'd0, 1'b0);
    cycle();
    idle();
    cmp("noncontig_err", 64'(bus.err), 64'd1);
    cmp("noncontig_count", 64'(bus.count), 64'd0);
    cmp("noncontig_out_valid", 64'(bus.out_valid), 64'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 15);
      if (r < 4) v = 2'b00;
      else if (r < 8) v = 2'b01;
      else if (r < 15) v = 2'b11;
      else v = 2'b10;
      if ((DEPTH - q.size() < WIDTH) && ($urandom_range(0, 7) != 0)) v = 2'b00;
      mx = (q.size() < WIDTH) ? q.size() : WIDTH;
      if ($urandom_range(0, 15) == 0) tk = 2'd3;
      else tk = 2'($urandom_range(0, mx));
      drive(v, $urandom, $urandom, 12'($urandom), 12'($urandom), tk,
            ($urandom_range(0, 31) == 0));
      reset = ($urandom_range(0, 63) != 0);
      cycle();
    end

    reset = 1'b1;
    idle();
    cycle();
    cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
